rtcl_hs_rx: RTL and testbench

- Receive-side counterpart of the RTCL high-speed byte-stream protocol.
- Consumes DPHY_LANES-byte beats. Each frame is one header beat flagged first, then packed little-endian raw data, ending with a beat flagged last.
- Strips and publishes the header, then regroups the data into CHANNELS×RAW_BITS pixel words with first/last framing.
- Sits after the D-PHY byte receiver, in front of the video pipeline.

---
 rtl/rtcl_hs_pkg.sv | 21 ++
 rtl/rtcl_hs_rx_gearbox.sv | 115 +++++++++++
 rtl/rtcl_hs_rx.sv | 158 +++++++++++++++
 tb/tb_rtcl_hs_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtcl_hs_pkg.sv
// rtcl_hs_pkg: shared definitions for the RTCL high-speed receive path.
//   P_CHANNELS / P_RAW_BITS / P_DPHY_LANES : default build configuration
//   W_S   : input beat width (bytes per beat * 8)
//   W_M   : output pixel word width (CHANNELS * RAW_BITS)
//   ACC_W : gearbox accumulator width (one word plus one beat)
//   state_t : receive FSM states
//   beat_t / word_t : beat and word types for the default configuration
package rtcl_hs_pkg;
  localparam int P_CHANNELS   = 4;
  localparam int P_RAW_BITS   = 10;
  localparam int P_DPHY_LANES = 2;

  localparam int W_S   = P_DPHY_LANES * 8;
  localparam int W_M   = P_CHANNELS * P_RAW_BITS;
  localparam int ACC_W = W_M + W_S;

  typedef enum logic [1:0] {HDR, DATA, DRAIN} state_t;

  typedef logic [W_S-1:0] beat_t;
  typedef logic [W_M-1:0] word_t;
endpackage

// File: rtl/rtcl_hs_rx_gearbox.sv
// rtcl_hs_rx_gearbox: regroups SW-bit beats into MW-bit words.
// An accumulator collects beats LSB-first; a complete word moves to a
// one-deep hold register and only reaches the output register when the
// next word completes or the frame is being drained. Holding back one
// word lets the frame's last flag be attached after the fact.
// Ports:
//   clk, reset, cke      : clock, async active-high reset, clock enable
//   i_beat, i_push       : data beat and its append strobe
//   i_hdr                : header accepted: clear accumulator/hold, arm first flag
//   i_drain              : frame ended, flush remaining words
//   i_m_tready           : downstream ready
//   o_room               : accumulator can take a beat without overrunning
//   o_drain_done         : drain step finishes this cycle
//   o_empty              : drain finished with no word produced in the frame
//   o_m_*                : output AXI4-Stream word with first/last
module rtcl_hs_rx_gearbox #(
  parameter int SW = 16,
  parameter int MW = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cke,
  input  logic [SW-1:0] i_beat,
  input  logic          i_push,
  input  logic          i_hdr,
  input  logic          i_drain,
  input  logic          i_m_tready,
  output logic          o_room,
  output logic          o_drain_done,
  output logic          o_empty,
  output logic          o_m_tvalid,
  output logic          o_m_tuser,
  output logic          o_m_tlast,
  output logic [MW-1:0] o_m_tdata
);
  localparam int AW = MW + SW;
  localparam int CW = $clog2(AW + 1);

  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_first_pend;
  logic [MW-1:0] r_hold;
  logic          r_hold_vld, r_hold_first;
  logic [MW-1:0] r_out;
  logic          r_out_vld, r_out_first, r_out_last;

  logic w_full, w_out_free, w_xfer, w_fin, w_load;

  assign w_full     = (r_cnt >= CW'(MW));
  assign w_out_free = !r_out_vld || i_m_tready;
  // accumulator -> hold; an occupied hold is pushed to output at the same time
  assign w_xfer     = w_full && (!r_hold_vld || w_out_free);
  // nothing left to complete while draining: hold is the frame's final word
  assign w_fin      = i_drain && !w_full && r_hold_vld && w_out_free;
  assign w_load     = (w_xfer && r_hold_vld) || w_fin;

  assign o_room       = !w_full && !(r_hold_vld && r_out_vld && !i_m_tready);
  assign o_drain_done = i_drain && !w_full && (!r_hold_vld || w_out_free);
  assign o_empty      = i_drain && !w_full && !r_hold_vld;

  assign o_m_tvalid = r_out_vld;
  assign o_m_tuser  = r_out_first;
  assign o_m_tlast  = r_out_last;
  assign o_m_tdata  = r_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_first_pend <= 1'b0;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_first <= 1'b0;
      r_out        <= '0;
      r_out_vld    <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
    end else if (cke) begin
      // accumulator; residue below one word is padding and is dropped on drain
      if (i_hdr || o_drain_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_push) begin
        r_acc <= r_acc | ({{MW{1'b0}}, i_beat} << r_cnt);
        r_cnt <= r_cnt + CW'(SW);
      end else if (w_xfer) begin
        r_acc <= r_acc >> MW;
        r_cnt <= r_cnt - CW'(MW);
      end

      // hold: a new header discards an unemitted word from an aborted frame
      if (i_hdr) begin
        r_hold_vld   <= 1'b0;
        r_first_pend <= 1'b1;
      end else if (w_xfer) begin
        r_hold       <= r_acc[MW-1:0];
        r_hold_vld   <= 1'b1;
        r_hold_first <= r_first_pend;
        r_first_pend <= 1'b0;
      end else if (w_fin) begin
        r_hold_vld <= 1'b0;
      end

      // output register: contents only change when free
      if (w_load) begin
        r_out       <= r_hold;
        r_out_vld   <= 1'b1;
        r_out_first <= r_hold_first;
        r_out_last  <= w_fin;
      end else if (i_m_tready) begin
        r_out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rtcl_hs_rx.sv
// rtcl_hs_rx: RTCL high-speed byte-stream receiver.
// Accepts DPHY_LANES-byte beats (header beat flagged by s_tuser, frame end
// by s_tlast), publishes the header and regroups the little-endian payload
// into CHANNELS*RAW_BITS pixel words with first/last framing.
// Requires DPHY_LANES*8 <= CHANNELS*RAW_BITS.
// Optional: define RTCL_HS_RX_ERRCNT_EN to add saturating 16-bit counters
// sync_error_count / frame_abort_count.
// Ports:
//   reset, clk, cke                 : async active-high reset, clock, enable
//   s_t*                            : input beat stream (AXI4-Stream)
//   m_t*                            : output word stream (AXI4-Stream)
//   header_data / header_valid      : last header and its one-cycle strobe
//   sync_error                      : non-header beat seen while idle
//   frame_abort                     : frame dropped (empty or interrupted)
module rtcl_hs_rx
  import rtcl_hs_pkg::*;
#(
  parameter int CHANNELS   = P_CHANNELS,
  parameter int RAW_BITS   = P_RAW_BITS,
  parameter int DPHY_LANES = P_DPHY_LANES
) (
  input  logic                         reset,
  input  logic                         clk,
  input  logic                         cke,
  input  logic                         s_tuser,
  input  logic                         s_tlast,
  input  logic [DPHY_LANES*8-1:0]      s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic                         m_tuser,
  output logic                         m_tlast,
  output logic [CHANNELS*RAW_BITS-1:0] m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DPHY_LANES*8-1:0]      header_data,
  output logic                         header_valid,
  output logic                         sync_error,
  output logic                         frame_abort
`ifdef RTCL_HS_RX_ERRCNT_EN
  ,
  output logic [15:0]                  sync_error_count,
  output logic [15:0]                  frame_abort_count
`endif
);
  localparam int SW = DPHY_LANES * 8;
  localparam int MW = CHANNELS * RAW_BITS;

  state_t        r_state, w_state_d;
  logic [SW-1:0] r_hdr_data;
  logic          r_hdr_vld, r_serr, r_abort;

  logic w_ready, w_hdr, w_push, w_abort, w_serr, w_drain;
  logic w_room, w_done, w_empty;

  rtcl_hs_rx_gearbox #(.SW(SW), .MW(MW)) u_gearbox (
    .clk         (clk),
    .reset       (reset),
    .cke         (cke),
    .i_beat      (s_tdata),
    .i_push      (w_push),
    .i_hdr       (w_hdr),
    .i_drain     (w_drain),
    .i_m_tready  (m_tready),
    .o_room      (w_room),
    .o_drain_done(w_done),
    .o_empty     (w_empty),
    .o_m_tvalid  (m_tvalid),
    .o_m_tuser   (m_tuser),
    .o_m_tlast   (m_tlast),
    .o_m_tdata   (m_tdata)
  );

  always_comb begin
    w_state_d = r_state;
    w_ready   = 1'b0;
    w_hdr     = 1'b0;
    w_push    = 1'b0;
    w_abort   = 1'b0;
    w_serr    = 1'b0;
    w_drain   = 1'b0;
    unique case (r_state)
      HDR: begin
        w_ready = 1'b1;
        if (s_tvalid) begin
          if (s_tuser) begin
            w_hdr = 1'b1;
            // header flagged last is an empty frame
            if (s_tlast) w_abort = 1'b1;
            else         w_state_d = DATA;
          end else begin
            w_serr = 1'b1;
          end
        end
      end
      DATA: begin
        w_ready = w_room;
        if (s_tvalid && w_room) begin
          if (s_tuser) begin
            // header mid-frame: drop the current frame and restart
            w_hdr   = 1'b1;
            w_abort = 1'b1;
            if (s_tlast) w_state_d = HDR;
          end else begin
            w_push = 1'b1;
            if (s_tlast) w_state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        w_drain = 1'b1;
        if (w_done) begin
          w_state_d = HDR;
          w_abort   = w_empty;
        end
      end
      default: w_state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HDR;
      r_hdr_data <= '0;
      r_hdr_vld  <= 1'b0;
      r_serr     <= 1'b0;
      r_abort    <= 1'b0;
    end else if (cke) begin
      r_state   <= w_state_d;
      if (w_hdr) r_hdr_data <= s_tdata;
      r_hdr_vld <= w_hdr;
      r_serr    <= w_serr;
      r_abort   <= w_abort;
    end
  end

  assign s_tready     = w_ready;
  assign header_data  = r_hdr_data;
  assign header_valid = r_hdr_vld;
  assign sync_error   = r_serr;
  assign frame_abort  = r_abort;

`ifdef RTCL_HS_RX_ERRCNT_EN
  logic [15:0] r_serr_cnt, r_abort_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_serr_cnt  <= '0;
      r_abort_cnt <= '0;
    end else if (cke) begin
      if (w_serr && r_serr_cnt != 16'hFFFF)    r_serr_cnt  <= r_serr_cnt + 16'd1;
      if (w_abort && r_abort_cnt != 16'hFFFF)  r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign sync_error_count  = r_serr_cnt;
  assign frame_abort_count = r_abort_cnt;
`endif
endmodule

// File: tb/tb_rtcl_hs_rx.sv
module tb_rtcl_hs_rx;
  localparam int SW = 16;
  localparam int MW = 40;
  localparam int SB = 8*MW + SW;

  logic          clk = 1'b0, reset = 1'b1, cke = 1'b1;
  logic          s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0;
  logic [SW-1:0] s_tdata = '0;
  logic          s_tready;
  logic          m_tuser, m_tlast, m_tvalid;
  logic [MW-1:0] m_tdata;
  logic          m_tready = 1'b0;
  logic [SW-1:0] header_data;
  logic          header_valid, sync_error, frame_abort;
`ifdef RTCL_HS_RX_ERRCNT_EN
  logic [15:0]   sync_error_count, frame_abort_count;
`endif

  rtcl_hs_rx dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .header_data(header_data), .header_valid(header_valid),
    .sync_error(sync_error), .frame_abort(frame_abort)
`ifdef RTCL_HS_RX_ERRCNT_EN
    , .sync_error_count(sync_error_count), .frame_abort_count(frame_abort_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [MW+1:0] exp_q[$];   // {last, first, data}
  logic [SW-1:0] hdr_q[$];
  int exp_serr = 0, exp_abort = 0, seen_serr = 0, seen_abort = 0;
  int stall_seen = 0;
  int rdy_mode = 0;          // 0: ready, 1: random 50%, 2: held low
  bit gap_en = 1'b0;
  logic [MW-1:0] wbuf[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_word: got %h expected none", m_tdata);
        end else begin
          logic [MW+1:0] e;
          e = exp_q.pop_front();
          check("word", 64'({m_tlast, m_tuser, m_tdata}), 64'(e));
        end
      end
      if (header_valid) begin
        if (hdr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_header: got %h expected none", header_data);
        end else begin
          logic [SW-1:0] h;
          h = hdr_q.pop_front();
          check("header", 64'(header_data), 64'(h));
        end
      end
      if (sync_error)  seen_serr++;
      if (frame_abort) seen_abort++;
      if (s_tvalid && !s_tready) stall_seen++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  task automatic send_beat(input logic u, input logic l, input logic [SW-1:0] d);
    int  t;
    bit  acc;
    t = 0; acc = 1'b0;
    s_tvalid = 1'b1; s_tuser = u; s_tlast = l; s_tdata = d;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      t++;
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: got no s_tready expected handshake for %h", d);
    end
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  // n words from wbuf; cut >= 0 sends only that many data beats (frame is
  // then interrupted by the next header)
  task automatic send_frame(input logic [SW-1:0] hdr, input int n, input int cut);
    logic [SB-1:0] stream;
    int nb, done;
    stream = '1;                       // padding bits are all ones
    for (int i = 0; i < n; i++) stream[i*MW +: MW] = wbuf[i];
    nb = (n*MW + SW - 1) / SW;
    hdr_q.push_back(hdr);
    if (cut < 0) begin
      for (int i = 0; i < n; i++) exp_q.push_back({i == n-1, i == 0, wbuf[i]});
      send_beat(1'b1, 1'b0, hdr);
      for (int b = 0; b < nb; b++) send_beat(1'b0, b == nb-1, stream[b*SW +: SW]);
    end else begin
      // the most recently completed word stays in hold and is discarded
      done = (cut*SW) / MW;
      for (int i = 0; i < done-1; i++) exp_q.push_back({1'b0, i == 0, wbuf[i]});
      exp_abort++;
      send_beat(1'b1, 1'b0, hdr);
      for (int b = 0; b < cut; b++) send_beat(1'b0, 1'b0, stream[b*SW +: SW]);
    end
  endtask

  task automatic fill_words(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom()};
      wbuf[i] = r[MW-1:0];
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0) && t < 3000) begin
      @(posedge clk); t++;
    end
    check("drain_words_left", 64'(exp_q.size()), 64'd0);
    check("drain_hdrs_left", 64'(hdr_q.size()), 64'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_sync_errors"}, 64'(seen_serr), 64'(exp_serr));
    check({tag, "_frame_aborts"}, 64'(seen_abort), 64'(exp_abort));
`ifdef RTCL_HS_RX_ERRCNT_EN
    check({tag, "_sync_error_count"}, 64'(sync_error_count), 64'(exp_serr));
    check({tag, "_frame_abort_count"}, 64'(frame_abort_count), 64'(exp_abort));
`endif
  endtask

  initial begin
    bit prev_cut;
    int n, nb, cut;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_header_data", 64'(header_data), 64'd0);
    check("rst_pulses", 64'({header_valid, sync_error, frame_abort}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_s_tready", 64'(s_tready), 64'd1);

    // four words 1..4 under header A55A
    for (int i = 0; i < 4; i++) wbuf[i] = MW'(i + 1);
    send_frame(16'hA55A, 4, -1);
    wait_drain();

    // three words: last beat carries a padding byte
    fill_words(3);
    send_frame(16'h0301, 3, -1);
    wait_drain();

    // same four-word frame under random back-pressure
    for (int i = 0; i < 4; i++) wbuf[i] = MW'(i + 1);
    rdy_mode = 1;
    send_frame(16'hA55A, 4, -1);
    wait_drain();
    rdy_mode = 0;

    // stray beat while idle, then a good frame
    exp_serr++;
    send_beat(1'b0, 1'b0, 16'h1234);
    fill_words(2);
    send_frame(16'h0222, 2, -1);
    wait_drain();

    // interrupted after two emitted words, new header BEEF
    fill_words(4);
    send_frame(16'h0C0C, 4, 8);
    fill_words(4);
    send_frame(16'hBEEF, 4, -1);
    wait_drain();
    check_counts("abort");

    // empty frame, and frames ending before any word completes
    hdr_q.push_back(16'hE001); exp_abort++;
    send_beat(1'b1, 1'b1, 16'hE001);
    hdr_q.push_back(16'hE002); exp_abort++;
    send_beat(1'b1, 1'b0, 16'hE002);
    send_beat(1'b0, 1'b1, 16'h5555);
    hdr_q.push_back(16'hE003); exp_abort++;
    send_beat(1'b1, 1'b0, 16'hE003);
    send_beat(1'b0, 1'b0, 16'h0001);
    send_beat(1'b0, 1'b1, 16'h0002);
    wait_drain();

    // randomized traffic
    rdy_mode = 1; gap_en = 1'b1; prev_cut = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!prev_cut && $urandom_range(0, 5) == 0) begin
        exp_serr++;
        send_beat(1'b0, 1'b0, 16'($urandom()));
      end
      n = $urandom_range(1, 6);
      nb = (n*MW + SW - 1) / SW;
      cut = (!prev_cut && $urandom_range(0, 4) == 0) ? $urandom_range(1, nb-1) : -1;
      fill_words(n);
      send_frame(16'($urandom()), n, cut);
      prev_cut = (cut >= 0);
    end
    fill_words(5);
    send_frame(16'h600D, 5, -1);
    wait_drain();
    check_counts("random");
    check("s_tready_stalled", 64'(stall_seen > 0), 64'd1);
    gap_en = 1'b0; rdy_mode = 0;

    // reset mid-frame with a word stuck on the output
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) wbuf[i] = MW'(i + 16);
    hdr_q.push_back(16'h7777);
    send_beat(1'b1, 1'b0, 16'h7777);
    send_beat(1'b0, 1'b0, 16'h0010);
    send_beat(1'b0, 1'b0, 16'h0000);
    send_beat(1'b0, 1'b0, 16'h1100);
    send_beat(1'b0, 1'b0, 16'h0000);
    send_beat(1'b0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_m_tvalid", 64'(m_tvalid), 64'd1);
    check("pre_reset_m_tdata", 64'(m_tdata), 64'h10);
    check("pre_reset_hdr_q", 64'(hdr_q.size()), 64'd0);
    check_counts("pre_reset");
    #2 reset = 1'b1;
    #1;
    check("async_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("async_rst_header_data", 64'(header_data), 64'd0);
    exp_q.delete(); hdr_q.delete();
    exp_serr = 0; exp_abort = 0; seen_serr = 0; seen_abort = 0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    fill_words(4);
    send_frame(16'h4242, 4, -1);
    wait_drain();
    check_counts("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end
endmodule
